// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alarm_pkg
// Brief    : Shared types, constants and width helpers for the alarm unit.
// Revision : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;
    localparam int TIME_W   = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    // Width able to hold (max(a,b) - 1); never narrower than one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Width able to hold 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_if.sv
`default_nettype none
// ============================================================================
// Module   : alarm_if
// Brief    : Calendar, load-handshake, control and status bundle of alarm_ctrl.
//            master = driving side (calendar/user), slave = alarm_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface alarm_if #(
    parameter int MAX_SNOOZE = 3
) ();
    localparam int CNT_W = alarm_pkg::cnt_width(MAX_SNOOZE);

    logic [alarm_pkg::TIME_W-1:0] Hours;
    logic [alarm_pkg::TIME_W-1:0] Mins;
    logic [alarm_pkg::TIME_W-1:0] Secs;
    logic                         set_valid;
    logic [alarm_pkg::TIME_W-1:0] set_hours;
    logic [alarm_pkg::TIME_W-1:0] set_mins;
    logic                         set_ready;
    logic                         set_err;
    logic                         arm;
    logic                         disarm;
    logic                         ack;
    logic                         snooze;
    logic                         armed;
    logic                         ring;
    logic [alarm_pkg::TIME_W-1:0] alarm_hours;
    logic [alarm_pkg::TIME_W-1:0] alarm_mins;
    logic [CNT_W-1:0]             snooze_cnt;

    modport master (
        output Hours, Mins, Secs, set_valid, set_hours, set_mins,
               arm, disarm, ack, snooze,
        input  set_ready, set_err, armed, ring, alarm_hours, alarm_mins, snooze_cnt
    );

    modport slave (
        input  Hours, Mins, Secs, set_valid, set_hours, set_mins,
               arm, disarm, ack, snooze,
        output set_ready, set_err, armed, ring, alarm_hours, alarm_mins, snooze_cnt
    );
endinterface
`default_nettype wire

// File: rtl/alarm_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : alarm_down_counter
// Brief    : Loadable down counter with zero flag; holds at zero.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_down_counter #(
    parameter int W = 8
) (
    input  wire          CLK,
    input  wire          RST,
    input  wire          load,
    input  wire  [W-1:0] load_val,
    input  wire          dec,
    output logic         zero
);
    logic [W-1:0] count;

    // Load wins over decrement; decrement stops at zero
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
endmodule
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_ctrl
// Brief    : Daily alarm: programmable alarm time, match against the live
//            calendar, bounded ring with ack/disarm and optional snooze.
//            Optional feature macro: ALARM_SNOOZE_EN (snooze state, snooze
//            timer and snooze counter are built only when defined).
// Revision : 1.0 - initial release
// ============================================================================
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 540,
    parameter int MAX_SNOOZE  = 3
) (
    input wire     CLK,
    input wire     RST,
    alarm_if.slave bus
);
    localparam int TMR_W = timer_width(RING_SECS, SNOOZE_SECS);
    localparam int CNT_W = cnt_width(MAX_SNOOZE);

    state_t              state;
    state_t              state_nxt;
    logic [TIME_W-1:0]   alm_hours;
    logic [TIME_W-1:0]   alm_mins;
    logic                err_pulse;
    logic                load_acc;
    logic                load_ok;
    logic                match;
    logic                ring_load;
    logic                ring_dec;
    logic                ring_zero;
    logic                cnt_clr;
`ifdef ALARM_SNOOZE_EN
    logic                snz_load;
    logic                snz_dec;
    logic                snz_zero;
    logic                snz_ok;
    logic                cnt_inc;
    logic [CNT_W-1:0]    cnt;
`endif

    assign load_acc = bus.set_valid && (state != RINGING);
    assign load_ok  = (bus.set_hours <= TIME_W'(MAX_HOUR)) &&
                      (bus.set_mins  <= TIME_W'(MAX_MIN));
    assign match    = (bus.Hours == alm_hours) && (bus.Mins == alm_mins) &&
                      (bus.Secs == '0);

    // Alarm time register and the registered out-of-range error pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            alm_hours <= '0;
            alm_mins  <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= load_acc && !load_ok;
            if (load_acc && load_ok) begin
                alm_hours <= bus.set_hours;
                alm_mins  <= bus.set_mins;
            end
        end
    end

    // State register; reset drops ring immediately since ring decodes state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and timer/counter controls; disarm > ack > snooze > timer/match
    always_comb begin
        state_nxt = state;
        ring_load = 1'b0;
        ring_dec  = 1'b0;
        cnt_clr   = 1'b0;
`ifdef ALARM_SNOOZE_EN
        snz_load  = 1'b0;
        snz_dec   = 1'b0;
        cnt_inc   = 1'b0;
`endif
        if (bus.disarm) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.arm) begin
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (match) begin
                        state_nxt = RINGING;
                        ring_load = 1'b1;
                        cnt_clr   = 1'b1;
                    end
                end
                RINGING: begin
                    if (bus.ack) begin
                        state_nxt = ARMED;
`ifdef ALARM_SNOOZE_EN
                    end else if (bus.snooze && snz_ok) begin
                        state_nxt = SNOOZE;
                        snz_load  = 1'b1;
                        cnt_inc   = 1'b1;
`endif
                    end else if (ring_zero) begin
                        state_nxt = ARMED;
                    end else begin
                        ring_dec = 1'b1;
                    end
                end
                SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                    if (snz_zero) begin
                        state_nxt = RINGING;
                        ring_load = 1'b1;
                    end else begin
                        snz_dec = 1'b1;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    alarm_down_counter #(.W(TMR_W)) u_ring_tmr (
        .CLK      (CLK),
        .RST      (RST),
        .load     (ring_load),
        .load_val (TMR_W'(RING_SECS - 1)),
        .dec      (ring_dec),
        .zero     (ring_zero)
    );

`ifdef ALARM_SNOOZE_EN
    alarm_down_counter #(.W(TMR_W)) u_snz_tmr (
        .CLK      (CLK),
        .RST      (RST),
        .load     (snz_load),
        .load_val (TMR_W'(SNOOZE_SECS - 1)),
        .dec      (snz_dec),
        .zero     (snz_zero)
    );

    assign snz_ok = (cnt < CNT_W'(MAX_SNOOZE));

    // Snoozes taken this event; increment is gated by snz_ok so it saturates
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.snooze_cnt = cnt;
`else
    logic unused_snooze;
    assign unused_snooze  = bus.snooze ^ cnt_clr;
    assign bus.snooze_cnt = CNT_W'(0);
`endif

    assign bus.armed       = (state != IDLE);
    assign bus.ring        = (state == RINGING);
    assign bus.set_ready   = (state != RINGING);
    assign bus.set_err     = err_pulse;
    assign bus.alarm_hours = alm_hours;
    assign bus.alarm_mins  = alm_mins;
endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_ctrl
// Brief    : Scoreboard bench for alarm_ctrl; expectations are queued with the
//            stimulus and compared one clock edge later. Honours
//            ALARM_SNOOZE_EN in the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_ctrl;
    localparam int K_RING  = 0;
    localparam int K_ARMED = 1;
    localparam int K_READY = 2;
    localparam int K_ERR   = 3;
    localparam int K_AH    = 4;
    localparam int K_AM    = 5;
    localparam int K_CNT   = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    alarm_if #(.MAX_SNOOZE(3)) bus ();

    alarm_ctrl #(
        .RING_SECS   (60),
        .SNOOZE_SECS (540),
        .MAX_SNOOZE  (3)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // 10 time-unit clock
    always #5 CLK = ~CLK;

    int    n_checks = 0;
    int    n_errors = 0;
    string sb_tag[$];
    int    sb_kind[$];
    int    sb_exp[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sample(input int kind);
        case (kind)
            K_RING:  return int'(bus.ring);
            K_ARMED: return int'(bus.armed);
            K_READY: return int'(bus.set_ready);
            K_ERR:   return int'(bus.set_err);
            K_AH:    return int'(bus.alarm_hours);
            K_AM:    return int'(bus.alarm_mins);
            K_CNT:   return int'(bus.snooze_cnt);
            default: return -1;
        endcase
    endfunction

    task automatic want(input string tag, input int kind, input int exp);
        sb_tag.push_back(tag);
        sb_kind.push_back(kind);
        sb_exp.push_back(exp);
    endtask

    task automatic drain();
        string t;
        int    k;
        int    e;
        while (sb_kind.size() > 0) begin
            t = sb_tag.pop_front();
            k = sb_kind.pop_front();
            e = sb_exp.pop_front();
            check(t, sample(k), e);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
        drain();
    endtask

    task automatic set_cal(input int h, input int m, input int s);
        bus.Hours = 6'(h);
        bus.Mins  = 6'(m);
        bus.Secs  = 6'(s);
    endtask

    task automatic load(input int h, input int m);
        bus.set_valid = 1'b1;
        bus.set_hours = 6'(h);
        bus.set_mins  = 6'(m);
    endtask

    // Present 07:30:00 for one edge, expect ring, then move the seconds on
    task automatic ring_start(input string tag);
        set_cal(7, 30, 0);
        want(tag, K_RING, 1);
        cyc();
        bus.Secs = 6'd1;
    endtask

    initial begin
        set_cal(0, 0, 0);
        bus.set_valid = 1'b0;
        bus.set_hours = '0;
        bus.set_mins  = '0;
        bus.arm       = 1'b0;
        bus.disarm    = 1'b0;
        bus.ack       = 1'b0;
        bus.snooze    = 1'b0;

        // Reset state
        #2;
        want("rst_ring",  K_RING,  0);
        want("rst_armed", K_ARMED, 0);
        want("rst_ready", K_READY, 1);
        want("rst_err",   K_ERR,   0);
        want("rst_ah",    K_AH,    0);
        want("rst_am",    K_AM,    0);
        want("rst_cnt",   K_CNT,   0);
        drain();
        cyc();
        cyc();
        RST = 1'b0;

        // 1: load 07:30, arm, ring exactly 60 cycles then timeout to ARMED
        set_cal(7, 29, 59);
        load(7, 30);
        want("t1_load_ah", K_AH, 7);
        want("t1_load_am", K_AM, 30);
        want("t1_load_err", K_ERR, 0);
        cyc();
        bus.set_valid = 1'b0;
        bus.arm = 1'b1;
        want("t1_armed", K_ARMED, 1);
        want("t1_no_ring", K_RING, 0);
        cyc();
        bus.arm = 1'b0;
        ring_start("t1_ring_on");
        for (int i = 2; i <= 60; i++) begin
            want("t1_ring_hold", K_RING, 1);
            cyc();
        end
        want("t1_timeout_ring", K_RING, 0);
        want("t1_timeout_armed", K_ARMED, 1);
        cyc();

        // 2/3: load blocked while ringing, ack at cycle 10, recur next day
        want("t2_ready_low", K_READY, 0);
        ring_start("t2_ring_on");
        load(5, 15);
        want("t3_busy_ah", K_AH, 7);
        want("t3_busy_am", K_AM, 30);
        want("t3_busy_ready", K_READY, 0);
        want("t2_ring_c2", K_RING, 1);
        cyc();
        bus.set_valid = 1'b0;
        for (int i = 3; i <= 10; i++) begin
            want("t2_ring_hold", K_RING, 1);
            cyc();
        end
        bus.ack = 1'b1;
        want("t2_ack_ring", K_RING, 0);
        want("t2_ack_armed", K_ARMED, 1);
        want("t2_ack_ready", K_READY, 1);
        cyc();
        bus.ack = 1'b0;
        set_cal(8, 0, 0);
        want("t2_day_quiet", K_RING, 0);
        cyc();
        ring_start("t2_next_day");
        bus.ack = 1'b1;
        want("t2_ack2_ring", K_RING, 0);
        cyc();
        bus.ack = 1'b0;

        // 3: out-of-range loads rejected with a one-cycle error pulse
        load(24, 0);
        want("t3_h24_err", K_ERR, 1);
        want("t3_h24_ah", K_AH, 7);
        want("t3_h24_am", K_AM, 30);
        cyc();
        bus.set_valid = 1'b0;
        want("t3_h24_pulse_end", K_ERR, 0);
        cyc();
        load(12, 60);
        want("t3_m60_err", K_ERR, 1);
        want("t3_m60_ah", K_AH, 7);
        want("t3_m60_am", K_AM, 30);
        cyc();
        bus.set_valid = 1'b0;
        want("t3_m60_pulse_end", K_ERR, 0);
        cyc();
        load(23, 59);
        want("t3_edge_ah", K_AH, 23);
        want("t3_edge_am", K_AM, 59);
        want("t3_edge_err", K_ERR, 0);
        cyc();
        load(7, 30);
        want("t3_restore_am", K_AM, 30);
        cyc();
        bus.set_valid = 1'b0;

        // 4: snooze behaviour
`ifdef ALARM_SNOOZE_EN
        want("t4_cnt_zero", K_CNT, 0);
        ring_start("t4_ring_on");
        for (int k = 1; k <= 3; k++) begin
            bus.snooze = 1'b1;
            want("t4_snz_ring", K_RING, 0);
            want("t4_snz_armed", K_ARMED, 1);
            want("t4_snz_cnt", K_CNT, k);
            cyc();
            bus.snooze = 1'b0;
            for (int i = 2; i <= 540; i++) begin
                want("t4_snz_quiet", K_RING, 0);
                cyc();
            end
            want("t4_rering", K_RING, 1);
            want("t4_rering_cnt", K_CNT, k);
            cyc();
        end
        bus.snooze = 1'b1;
        want("t4_4th_ring", K_RING, 1);
        want("t4_4th_cnt", K_CNT, 3);
        cyc();
        bus.snooze = 1'b0;
        bus.ack = 1'b1;
        want("t4_ack_ring", K_RING, 0);
        want("t4_ack_cnt", K_CNT, 3);
        cyc();
        bus.ack = 1'b0;
        want("t4_match_clr", K_CNT, 0);
        ring_start("t4_new_event");
`else
        ring_start("t4_ring_on");
        bus.snooze = 1'b1;
        want("t4_snz_ignored", K_RING, 1);
        want("t4_snz_cnt", K_CNT, 0);
        cyc();
        bus.snooze = 1'b0;
        for (int i = 0; i < 5; i++) begin
            want("t4_ring_cont", K_RING, 1);
            cyc();
        end
`endif
        bus.ack = 1'b1;
        want("t4_stop", K_RING, 0);
        cyc();
        bus.ack = 1'b0;

        // 5: disarm beats ack; no ring afterwards; arm+match gives no ring
        ring_start("t5_ring_on");
        bus.disarm = 1'b1;
        bus.ack    = 1'b1;
        want("t5_dis_ring", K_RING, 0);
        want("t5_dis_armed", K_ARMED, 0);
        cyc();
        bus.disarm = 1'b0;
        bus.ack    = 1'b0;
        set_cal(7, 30, 0);
        want("t5_idle_ring", K_RING, 0);
        want("t5_idle_armed", K_ARMED, 0);
        cyc();
        bus.arm = 1'b1;
        want("t5_arm_match_armed", K_ARMED, 1);
        want("t5_arm_match_ring", K_RING, 0);
        cyc();
        bus.arm = 1'b0;
        bus.Secs = 6'd1;
        want("t5_after_arm_ring", K_RING, 0);
        cyc();

        // 6: asynchronous reset mid-ring
        ring_start("t6_ring_on");
        want("t6_ring_hold", K_RING, 1);
        cyc();
        #3;
        RST = 1'b1;
        #1;
        want("t6_async_ring", K_RING, 0);
        want("t6_async_armed", K_ARMED, 0);
        want("t6_async_ah", K_AH, 0);
        want("t6_async_am", K_AM, 0);
        want("t6_async_ready", K_READY, 1);
        drain();
        cyc();
        RST = 1'b0;
        set_cal(0, 0, 0);
        want("t6_post_idle", K_ARMED, 0);
        want("t6_post_ring", K_RING, 0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
